instruction_buffer: RTL and testbench
=====================================

Name: instruction_buffer

Overview:
- Receiving end of the fetch/decode 4-wide bundle interface.
- Captures decoded instruction slots into a circular queue and returns the `num_fetch` slot-availability credit that fetch uses to advance its PC.
- Presents up to 4 oldest entries, in program order, to dispatch/reservation-station logic.
- Flushed on a taken jump from the branch unit.

Parameters:
- DEPTH, 16, number of entries; power of two, at least 8.
- EW, 38, entry width in bits. The field order below is fixed; EW is not meant to be overridden.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  taken jump; discards all contents
- if_valid_in  in  1  4-slot bundle present this cycle
- opcode_in_flat  in  16  4 bits per slot
- immediate_in_flat  in  32  8 bits per slot
- op_a_local_dep_in_flat  in  4  1 bit per slot
- op_a_owner_in_flat  in  16  4 bits per slot
- op_b_local_dep_in_flat  in  4  1 bit per slot
- op_b_owner_in_flat  in  16  4 bits per slot
- rt_in_flat  in  16  4 bits per slot
- ra_in_flat  in  16  4 bits per slot
- rb_in_flat  in  16  4 bits per slot
- uses_rb_in_flat, is_ld_str_in_flat, is_fxu_in_flat, is_branch_in_flat  in  4 each  1 bit per slot
- num_fetch  out  3  credit to fetch: 4 or 0
- deq_count  in  3  entries taken by dispatch this cycle, 0..4
- out_valid_flat  out  4  per-slot valid for presented entries
- out_entry_flat  out  4*EW  presented entries, oldest at slot 0
- occupancy  out  $clog2(DEPTH+1)  current entry count
- overflow_err  out  1  sticky: bundle arrived without credit

Behaviour:
- Flat packing: slot k of a W-bit field occupies bits [W*(3-k)+W-1 : W*(3-k)]. Slot 0 is in the MSBs and is the oldest in program order.
- Entry layout, MSB to LSB: opcode[4], imm[8], a_dep, a_owner[4], b_dep, b_owner[4], rt[4], ra[4], rb[4], uses_rb, is_ld_str, is_fxu, is_branch. Total 38 bits.
- State: head pointer, tail pointer (log2 DEPTH bits, wrap modulo DEPTH), occupancy count (0..DEPTH), overflow flag.
- Credit: `num_fetch` = 4 when (DEPTH - occupancy) >= 4, else 0.
  - Combinational from registered state only; no same-cycle dequeue bypass.
- Enqueue: when if_valid_in && num_fetch==4 && !flush:
  - write slots 0..3 to tail, tail+1, tail+2, tail+3 (wrapping);
  - tail += 4.
  - Transfer is all-or-nothing; partial bundles are never accepted.
- Overflow: when if_valid_in && num_fetch==0 && !flush:
  - bundle is dropped;
  - overflow_err set; it holds until rst.
- Dequeue: effective count d = min(deq_count, occupancy); head += d. Out-of-range requests are clamped, never underflow.
- Next occupancy = occupancy + 4*enq - d. Simultaneous enqueue and dequeue are both applied.
- Read side (combinational from storage):
  - out slot k = entry[head+k];
  - out_valid_flat bit for slot k = (k < occupancy).
  - Entries written at edge N are visible after edge N; fetch-to-dispatch latency is 1 cycle.
- Flush: head = tail = 0 and occupancy = 0 at the next edge.
  - Overrides enqueue and dequeue in the same cycle.
  - Does not clear overflow_err.
  - num_fetch returns to 4 the cycle after the flush edge.
- Reset: head = tail = occupancy = 0, overflow_err = 0, out_valid_flat = 0, num_fetch = 4 (post-reset). Storage contents are don't-care.
  - Reset asserted mid-operation discards everything at that edge.
  - Reset has priority over flush and enqueue.
- No reordering and no field modification: owner tags and dependency bits pass through untouched.

Test Plan:
- Reset, then one bundle with opcodes 0,1,2,3, rt 1,2,3,4 -> next cycle occupancy=4, out_valid_flat=4'b1111, slot0 opcode=0, slot3 rt=4, num_fetch=4.
- Four back-to-back bundles with deq_count=0 (DEPTH=16) -> occupancy=16, num_fetch=0. A fifth bundle -> dropped, overflow_err=1, occupancy stays 16.
- occupancy=12, enqueue plus deq_count=3 in the same cycle -> occupancy=13, head advanced 3, slot0 = the former 4th entry.
- Tail at 14 and occupancy=0, then enqueue -> entries land at 14,15,0,1. Dequeue 4 -> program order preserved across the wrap, occupancy=0.
- occupancy=2, deq_count=4 -> clamped to 2, occupancy=0, out_valid_flat=0.
- occupancy=8 with flush, if_valid_in and deq_count=2 all asserted -> occupancy=0, out_valid_flat=0, num_fetch=4 next cycle, overflow_err unchanged.

Source files
------------

// File: rtl/instruction_buffer.sv
// Circular instruction queue between fetch and dispatch: accepts whole 4-slot
// bundles against a credit and presents the four oldest entries in program order.
module instruction_buffer #(
    parameter int DEPTH = 16,
    parameter int EW    = 38
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            if_valid_in,
    input  logic [15:0]     opcode_in_flat,
    input  logic [31:0]     immediate_in_flat,
    input  logic [3:0]      op_a_local_dep_in_flat,
    input  logic [15:0]     op_a_owner_in_flat,
    input  logic [3:0]      op_b_local_dep_in_flat,
    input  logic [15:0]     op_b_owner_in_flat,
    input  logic [15:0]     rt_in_flat,
    input  logic [15:0]     ra_in_flat,
    input  logic [15:0]     rb_in_flat,
    input  logic [3:0]      uses_rb_in_flat,
    input  logic [3:0]      is_ld_str_in_flat,
    input  logic [3:0]      is_fxu_in_flat,
    input  logic [3:0]      is_branch_in_flat,
    output logic [2:0]      num_fetch,
    input  logic [2:0]      deq_count,
    output logic [3:0]      out_valid_flat,
    output logic [4*EW-1:0] out_entry_flat,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic            overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          ovf_q, ovf_d;

    logic [EW-1:0] inEntry [4];
    logic          creditOk;
    logic          enq;
    logic [2:0]    deqEff;

    // Slot k of every flat input sits at W*(3-k); slot 0 (oldest) is in the MSBs.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            inEntry[k] = {opcode_in_flat[4*(3-k) +: 4],
                          immediate_in_flat[8*(3-k) +: 8],
                          op_a_local_dep_in_flat[3-k],
                          op_a_owner_in_flat[4*(3-k) +: 4],
                          op_b_local_dep_in_flat[3-k],
                          op_b_owner_in_flat[4*(3-k) +: 4],
                          rt_in_flat[4*(3-k) +: 4],
                          ra_in_flat[4*(3-k) +: 4],
                          rb_in_flat[4*(3-k) +: 4],
                          uses_rb_in_flat[3-k],
                          is_ld_str_in_flat[3-k],
                          is_fxu_in_flat[3-k],
                          is_branch_in_flat[3-k]};
        end
    end

    // Credit depends only on registered occupancy, so fetch never sees a same-cycle dequeue.
    assign creditOk  = (CW'(DEPTH) - occ_q) >= CW'(4);
    assign num_fetch = creditOk ? 3'd4 : 3'd0;
    assign enq       = if_valid_in && creditOk && !flush;

    always_comb begin
        deqEff = deq_count;
        if (deqEff > 3'd4) begin
            deqEff = 3'd4;
        end
        if (CW'(deqEff) > occ_q) begin
            deqEff = 3'(occ_q);
        end
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        ovf_d  = ovf_q | (if_valid_in && !creditOk && !flush);
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            head_d = head_q + PW'(deqEff);
            if (enq) begin
                tail_d = tail_q + PW'(4);
            end
            occ_d = occ_q + (enq ? CW'(4) : CW'(0)) - CW'(deqEff);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            ovf_q  <= ovf_d;
        end
    end

    // Storage holds no reset; stale contents are masked by occupancy.
    always_ff @(posedge clk) begin
        if (enq && !rst) begin
            for (int k = 0; k < 4; k++) begin
                mem_q[tail_q + PW'(k)] <= inEntry[k];
            end
        end
    end

    always_comb begin
        out_entry_flat = '0;
        out_valid_flat = '0;
        for (int k = 0; k < 4; k++) begin
            out_entry_flat[EW*(3-k) +: EW] = mem_q[head_q + PW'(k)];
            out_valid_flat[3-k]            = occ_q > CW'(k);
        end
    end

    assign occupancy    = occ_q;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_instruction_buffer.sv
// Scoreboard bench for instruction_buffer: accepted bundles push expected entries,
// a negedge monitor pops them as dispatch consumes the presented slots.
module tb_instruction_buffer;

    localparam int DEPTH = 16;
    localparam int EW    = 38;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            if_valid_in;
    logic [15:0]     opcode_in_flat;
    logic [31:0]     immediate_in_flat;
    logic [3:0]      op_a_local_dep_in_flat;
    logic [15:0]     op_a_owner_in_flat;
    logic [3:0]      op_b_local_dep_in_flat;
    logic [15:0]     op_b_owner_in_flat;
    logic [15:0]     rt_in_flat;
    logic [15:0]     ra_in_flat;
    logic [15:0]     rb_in_flat;
    logic [3:0]      uses_rb_in_flat;
    logic [3:0]      is_ld_str_in_flat;
    logic [3:0]      is_fxu_in_flat;
    logic [3:0]      is_branch_in_flat;
    logic [2:0]      num_fetch;
    logic [2:0]      deq_count;
    logic [3:0]      out_valid_flat;
    logic [4*EW-1:0] out_entry_flat;
    logic [4:0]      occupancy;
    logic            overflow_err;

    int compared   = 0;
    int mismatched = 0;
    logic [EW-1:0] expQ [$];

    instruction_buffer #(.DEPTH(DEPTH), .EW(EW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .if_valid_in(if_valid_in),
        .opcode_in_flat(opcode_in_flat), .immediate_in_flat(immediate_in_flat),
        .op_a_local_dep_in_flat(op_a_local_dep_in_flat), .op_a_owner_in_flat(op_a_owner_in_flat),
        .op_b_local_dep_in_flat(op_b_local_dep_in_flat), .op_b_owner_in_flat(op_b_owner_in_flat),
        .rt_in_flat(rt_in_flat), .ra_in_flat(ra_in_flat), .rb_in_flat(rb_in_flat),
        .uses_rb_in_flat(uses_rb_in_flat), .is_ld_str_in_flat(is_ld_str_in_flat),
        .is_fxu_in_flat(is_fxu_in_flat), .is_branch_in_flat(is_branch_in_flat),
        .num_fetch(num_fetch), .deq_count(deq_count), .out_valid_flat(out_valid_flat),
        .out_entry_flat(out_entry_flat), .occupancy(occupancy), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    // Slot k of bundle "base" carries value v = base+k spread over every field.
    function automatic logic [EW-1:0] makeEntry(input int base, input int k);
        logic [7:0] v;
        v = 8'(base + k);
        return {v[3:0], v ^ 8'h5A, v[0], ~v[3:0], v[1], v[3:0] + 4'd3,
                v[3:0] + 4'd1, v[3:0] + 4'd2, v[3:0] + 4'd5, v[3:0]};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int base, input bit vld, input int deq,
                                 input bit fl, input bit rs, input bit expectAccept);
        logic [EW-1:0] e;
        if (fl || rs) expQ.delete();
        for (int k = 0; k < 4; k++) begin
            e = makeEntry(base, k);
            opcode_in_flat[4*(3-k) +: 4]     = e[37:34];
            immediate_in_flat[8*(3-k) +: 8]  = e[33:26];
            op_a_local_dep_in_flat[3-k]      = e[25];
            op_a_owner_in_flat[4*(3-k) +: 4] = e[24:21];
            op_b_local_dep_in_flat[3-k]      = e[20];
            op_b_owner_in_flat[4*(3-k) +: 4] = e[19:16];
            rt_in_flat[4*(3-k) +: 4]         = e[15:12];
            ra_in_flat[4*(3-k) +: 4]         = e[11:8];
            rb_in_flat[4*(3-k) +: 4]         = e[7:4];
            uses_rb_in_flat[3-k]             = e[3];
            is_ld_str_in_flat[3-k]           = e[2];
            is_fxu_in_flat[3-k]              = e[1];
            is_branch_in_flat[3-k]           = e[0];
            if (expectAccept) expQ.push_back(e);
        end
        if_valid_in = vld;
        deq_count   = 3'(deq);
        flush       = fl;
        rst         = rs;
        @(posedge clk);
        #1;
        if_valid_in = 1'b0;
        deq_count   = 3'd0;
        flush       = 1'b0;
        rst         = 1'b0;
    endtask

    // Monitor: every slot dispatch consumes must match the next expected entry.
    always @(negedge clk) begin
        int nVal;
        int n;
        logic [EW-1:0] want;
        logic [EW-1:0] got;
        if (!rst && !flush) begin
            nVal = 0;
            for (int k = 0; k < 4; k++) if (out_valid_flat[3-k]) nVal++;
            n = (int'(deq_count) < nVal) ? int'(deq_count) : nVal;
            for (int k = 0; k < n; k++) begin
                got = out_entry_flat[EW*(3-k) +: EW];
                compared++;
                if (expQ.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL scoreboard slot%0d: got %h, expected nothing", k, got);
                end else begin
                    want = expQ.pop_front();
                    if (got !== want) begin
                        mismatched++;
                        $display("[TB] FAIL scoreboard slot%0d: got %h, expected %h", k, got, want);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; if_valid_in = 1'b0; deq_count = 3'd0;
        opcode_in_flat = '0; immediate_in_flat = '0; op_a_local_dep_in_flat = '0;
        op_a_owner_in_flat = '0; op_b_local_dep_in_flat = '0; op_b_owner_in_flat = '0;
        rt_in_flat = '0; ra_in_flat = '0; rb_in_flat = '0; uses_rb_in_flat = '0;
        is_ld_str_in_flat = '0; is_fxu_in_flat = '0; is_branch_in_flat = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        checkOutput("rst_occ", occupancy, 0);
        checkOutput("rst_valid", out_valid_flat, 0);
        checkOutput("rst_credit", num_fetch, 4);
        checkOutput("rst_ovf", overflow_err, 0);

        applyStimulus(0, 1, 0, 0, 0, 1);
        checkOutput("b0_occ", occupancy, 4);
        checkOutput("b0_valid", out_valid_flat, 4'b1111);
        checkOutput("b0_slot0_opcode", out_entry_flat[4*EW-1 -: 4], 0);
        checkOutput("b0_slot3_rt", out_entry_flat[15:12], 4);
        checkOutput("b0_credit", num_fetch, 4);

        applyStimulus(4, 1, 0, 0, 0, 1);
        applyStimulus(8, 1, 0, 0, 0, 1);
        applyStimulus(12, 1, 0, 0, 0, 1);
        checkOutput("full_occ", occupancy, 16);
        checkOutput("full_credit", num_fetch, 0);
        checkOutput("full_ovf_clear", overflow_err, 0);

        applyStimulus(16, 1, 0, 0, 0, 0);
        checkOutput("drop_occ", occupancy, 16);
        checkOutput("drop_ovf", overflow_err, 1);

        applyStimulus(0, 0, 4, 0, 0, 0);
        checkOutput("deq4_occ", occupancy, 12);
        checkOutput("deq4_credit", num_fetch, 4);

        applyStimulus(20, 1, 3, 0, 0, 1);
        checkOutput("enqdeq_occ", occupancy, 13);
        checkOutput("enqdeq_slot0_opcode", out_entry_flat[4*EW-1 -: 4], 7);
        checkOutput("enqdeq_credit", num_fetch, 0);

        applyStimulus(0, 0, 4, 0, 0, 0);
        applyStimulus(0, 0, 4, 0, 0, 0);
        applyStimulus(0, 0, 4, 0, 0, 0);
        checkOutput("one_left_occ", occupancy, 1);
        checkOutput("one_left_valid", out_valid_flat, 4'b1000);

        applyStimulus(24, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 3, 0, 0, 0);
        checkOutput("two_left_occ", occupancy, 2);
        applyStimulus(0, 0, 4, 0, 0, 0);
        checkOutput("clamp_occ", occupancy, 0);
        checkOutput("clamp_valid", out_valid_flat, 0);

        applyStimulus(28, 1, 0, 0, 0, 1);
        applyStimulus(32, 1, 2, 0, 0, 1);
        applyStimulus(36, 1, 4, 0, 0, 1);
        checkOutput("wrap_occ", occupancy, 6);
        checkOutput("wrap_slot0_opcode", out_entry_flat[4*EW-1 -: 4], 2);
        checkOutput("wrap_slot2_opcode", out_entry_flat[2*EW-1 -: 4], 4);
        applyStimulus(0, 0, 4, 0, 0, 0);
        checkOutput("wrap_drain_occ", occupancy, 2);

        applyStimulus(40, 1, 0, 0, 0, 1);
        applyStimulus(44, 1, 2, 0, 0, 1);
        checkOutput("pre_flush_occ", occupancy, 8);
        applyStimulus(48, 1, 2, 1, 0, 0);
        checkOutput("flush_occ", occupancy, 0);
        checkOutput("flush_valid", out_valid_flat, 0);
        checkOutput("flush_credit", num_fetch, 4);
        checkOutput("flush_keeps_ovf", overflow_err, 1);

        applyStimulus(52, 1, 0, 0, 0, 1);
        checkOutput("post_flush_occ", occupancy, 4);
        checkOutput("post_flush_slot0_opcode", out_entry_flat[4*EW-1 -: 4], 4);
        applyStimulus(0, 0, 4, 0, 0, 0);

        applyStimulus(56, 1, 0, 0, 0, 1);
        applyStimulus(60, 1, 1, 1, 1, 0);
        checkOutput("reset_mid_occ", occupancy, 0);
        checkOutput("reset_mid_ovf", overflow_err, 0);
        checkOutput("reset_mid_valid", out_valid_flat, 0);
        checkOutput("reset_mid_credit", num_fetch, 4);

        applyStimulus(64, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 2, 0, 0, 0);
        applyStimulus(0, 0, 2, 0, 0, 0);
        checkOutput("final_occ", occupancy, 0);
        checkOutput("final_queue_drained", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
